// File: rtl/gate_bank.sv
// gate_bank: the ten fixed logic functions of a, b, c, d, built only from
// gate primitives so gate-level flows see a one-to-one structural netlist.
// Bit i of f carries output o(i+1).
module gate_bank (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output wire  [9:0] f
);

    wire ab;
    wire cd;

    and  u_and4  (f[0], a, b, c, d);
    or   u_or4   (f[1], a, b, c, d);
    nand u_nand2 (f[2], a, b);
    nor  u_nor2  (f[3], c, d);
    xor  u_xor2  (f[4], a, b);
    xnor u_xnor2 (f[5], c, d);
    not  u_not   (f[6], a);
    buf  u_buf   (f[7], b);

    // AOI22 is an AND pair feeding a NOR
    and  u_aoi_ab (ab, a, b);
    and  u_aoi_cd (cd, c, d);
    nor  u_aoi_nr (f[8], ab, cd);

    xor  u_xor4  (f[9], a, b, c, d);

endmodule

// File: rtl/built_in_gates.sv
// built_in_gates: gate_bank followed by an optional 10-bit register bank.
// With REG_OUT=1 the outputs are glitch-free, cleared asynchronously by rst
// and lag the inputs by one clock; with REG_OUT=0 they are the raw gate
// results and clk/rst are unused.
module built_in_gates #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8,
    output logic o9,
    output logic o10
);

    wire  [9:0] func;
    logic [9:0] out_q;

    gate_bank u_gate_bank (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .f (func)
    );

    generate
        if (REG_OUT) begin : g_reg
            // Capture all ten results together; reset clears them without a clock edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= '0;
                end else begin
                    out_q <= func;
                end
            end
        end else begin : g_comb
            // Bypass: outputs follow the gates directly
            always_comb begin
                out_q = func;
            end
        end
    endgenerate

    assign {o10, o9, o8, o7, o6, o5, o4, o3, o2, o1} = out_q;

endmodule

// File: tb/tb_built_in_gates.sv
// tb_built_in_gates: scoreboard bench for the registered instance plus
// direct checks of the reset behaviour and of a combinational instance.
module tb_built_in_gates;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic r1, r2, r3, r4, r5, r6, r7, r8, r9, r10;

    logic clk_c = 1'b0;
    logic rst_c = 1'b1;
    logic ac = 1'b0, bc = 1'b0, cc = 1'b0, dc = 1'b0;
    logic n1, n2, n3, n4, n5, n6, n7, n8, n9, n10;

    int applied = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];

    // Vectors and expectations from the test plan, {o1..o10} left to right
    logic [3:0] plan_in  [5] = '{4'b1010, 4'b0101, 4'b0010, 4'b1111, 4'b0000};
    logic [9:0] plan_exp [5] = '{10'b0110100010, 10'b0110101110, 10'b0110001011,
                                 10'b1100010100, 10'b0011011010};

    built_in_gates #(.REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .o1(r1), .o2(r2), .o3(r3), .o4(r4), .o5(r5),
        .o6(r6), .o7(r7), .o8(r8), .o9(r9), .o10(r10)
    );

    built_in_gates #(.REG_OUT(1'b0)) dut_comb (
        .clk(clk_c), .rst(rst_c), .a(ac), .b(bc), .c(cc), .d(dc),
        .o1(n1), .o2(n2), .o3(n3), .o4(n4), .o5(n5),
        .o6(n6), .o7(n7), .o8(n8), .o9(n9), .o10(n10)
    );

    wire [9:0] reg_vec  = {r1, r2, r3, r4, r5, r6, r7, r8, r9, r10};
    wire [9:0] comb_vec = {n1, n2, n3, n4, n5, n6, n7, n8, n9, n10};

    initial forever #5 clk = ~clk;

    // Reference: each function expressed by counting ones, result {o1..o10}
    function automatic logic [9:0] model(input logic [3:0] v);
        int ia, ib, ic, id, n_ab, n_cd, n_all;
        logic [9:0] r;
        ia = int'(v[3]); ib = int'(v[2]); ic = int'(v[1]); id = int'(v[0]);
        n_ab = ia + ib;
        n_cd = ic + id;
        n_all = n_ab + n_cd;
        r[9] = (n_all == 4);
        r[8] = (n_all != 0);
        r[7] = (n_ab != 2);
        r[6] = (n_cd == 0);
        r[5] = (n_ab == 1);
        r[4] = (n_cd != 1);
        r[3] = (ia == 0);
        r[2] = (ib == 1);
        r[1] = !(n_ab == 2 || n_cd == 2);
        r[0] = (n_all % 2 == 1);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [9:0] got,
                                input logic [9:0] want);
        applied++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b (o1..o10)", name, got, want);
        end
    endtask

    // Drive one vector ahead of the capturing edge, then disturb the inputs
    // after that edge to show mid-cycle changes do not reach the outputs
    task automatic apply_stimulus(input logic [3:0] v);
        @(negedge clk);
        #2;
        {a, b, c, d} = v;
        exp_q.push_back(model(v));
        @(posedge clk);
        #2;
        {a, b, c, d} = 4'($urandom_range(15));
    endtask

    // Monitor: each falling edge shows the result captured at the preceding rising edge
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("reg_scoreboard", reg_vec, e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset asserted before any clock edge
        #1 rst = 1'b1;
        #1 check_output("reset_immediate", reg_vec, 10'b0);
        @(posedge clk); #1;
        check_output("reset_hold", reg_vec, 10'b0);
        @(negedge clk); #2 rst = 1'b0;

        foreach (plan_in[i]) apply_stimulus(plan_in[i]);
        for (int i = 0; i < 200; i++) apply_stimulus(4'($urandom_range(15)));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end

        // Reset in mid-operation with abcd=0000 registered
        @(negedge clk); #2 {a, b, c, d} = 4'b0000;
        @(posedge clk); #1;
        check_output("midrun_loaded", reg_vec, model(4'b0000));
        rst = 1'b1;
        #1 check_output("midrun_reset_async", reg_vec, 10'b0);
        @(posedge clk); #1;
        check_output("midrun_reset_hold", reg_vec, 10'b0);
        @(negedge clk); #2 rst = 1'b0;
        #1 check_output("midrun_no_edge_yet", reg_vec, 10'b0);
        @(posedge clk); #1;
        check_output("midrun_first_edge", reg_vec, model(4'b0000));

        // Combinational instance: clock stopped, reset held high
        foreach (plan_in[i]) begin
            {ac, bc, cc, dc} = plan_in[i];
            #1 check_output("comb_plan", comb_vec, plan_exp[i]);
        end
        for (int i = 0; i < 50; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(15));
            {ac, bc, cc, dc} = v;
            #1 check_output("comb_random", comb_vec, model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
